// File: rtl/cvif_rd_wrr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cvif_rd_wrr_arb
//  Description : Weighted round-robin read-request arbiter for the CVIF read
//                path. Shares one DMA read-request port between NUM_CLIENTS
//                engine clients (bdma, sdp, pdp, cdp, ...), throttled by an
//                outstanding-read limit, and reports idle to the CSB status.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    nvdla_core_clk   in   core clock
//    nvdla_core_rstn  in   asynchronous active-low reset
//    req_valid        in   [NUM_CLIENTS]     per-client request valid
//    req_ready        out  [NUM_CLIENTS]     per-client accept (one-hot)
//    req_pd           in   [NUM_CLIENTS*PW]  client i payload at [i*PW +: PW]
//    rd_weight        in   [NUM_CLIENTS*8]   client i weight at [i*8 +: 8]
//    rd_os_cnt        in   [8]               max outstanding reads
//    dma_req_valid    out  arbitrated request valid (registered)
//    dma_req_ready    in   downstream accept
//    dma_req_pd       out  [PW]  arbitrated payload
//    dma_req_id       out  [IDW] granted client index
//    rsp_done         in   one-cycle pulse per completed read
//    idle             out  no pending, held or outstanding work
// ============================================================================
module cvif_rd_wrr_arb #(
  parameter int NUM_CLIENTS = 4,
  parameter int PW          = 79,
  parameter int IDW         = 4
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic [NUM_CLIENTS-1:0]    req_valid,
  output logic [NUM_CLIENTS-1:0]    req_ready,
  input  logic [NUM_CLIENTS*PW-1:0] req_pd,
  input  logic [NUM_CLIENTS*8-1:0]  rd_weight,
  input  logic [7:0]                rd_os_cnt,
  output logic                      dma_req_valid,
  input  logic                      dma_req_ready,
  output logic [PW-1:0]             dma_req_pd,
  output logic [IDW-1:0]            dma_req_id,
  input  logic                      rsp_done,
  output logic                      idle
);

  // Clients are padded out to a power-of-two slot count so every lookup is
  // indexed by a full IDW-bit client index; padding slots are never eligible.
  localparam int             c_num_slots = 1 << IDW;
  localparam logic [IDW-1:0] c_last_rst  = IDW'(NUM_CLIENTS - 1);

  // Registered state
  logic           dma_req_valid_q, dma_req_valid_d;
  logic [PW-1:0]  dma_req_pd_q,    dma_req_pd_d;
  logic [IDW-1:0] dma_req_id_q,    dma_req_id_d;
  logic [IDW-1:0] last_q,          last_d;
  logic [7:0]     quota_q,         quota_d;
  logic [8:0]     os_count_q,      os_count_d;

  // Per-slot views of the flattened client buses
  logic [c_num_slots-1:0] w_slot_valid;
  logic [c_num_slots-1:0] w_slot_elig;
  logic [7:0]             w_slot_weight [c_num_slots];
  logic [PW-1:0]          w_slot_pd     [c_num_slots];

  // Arbitration
  logic           w_any_eligible;
  logic [IDW-1:0] w_rot_idx;
  logic           w_continue;
  logic [IDW-1:0] w_grant_idx;
  logic           w_credit_ok;
  logic           w_load;
  logic           w_rsp_dec;

  generate
    for (genvar gi = 0; gi < c_num_slots; gi++) begin : g_slot
      if (gi < NUM_CLIENTS) begin : g_live
        assign w_slot_valid[gi]  = req_valid[gi];
        assign w_slot_weight[gi] = rd_weight[gi*8 +: 8];
        assign w_slot_pd[gi]     = req_pd[gi*PW +: PW];
      end else begin : g_pad
        assign w_slot_valid[gi]  = 1'b0;
        assign w_slot_weight[gi] = 8'd0;
        assign w_slot_pd[gi]     = '0;
      end
      // A zero weight removes the client from arbitration altogether.
      assign w_slot_elig[gi] = w_slot_valid[gi] & (w_slot_weight[gi] != 8'd0);
    end
  endgenerate

  // Rotating scan starting just after the last rotation winner. The scan
  // covers every client (the last winner is visited last), so finding
  // nothing means nobody is eligible.
  always_comb begin : p_rotate
    int pos;
    pos            = 0;
    w_any_eligible = 1'b0;
    w_rot_idx      = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      pos = int'(last_q) + k;
      if (pos >= NUM_CLIENTS) begin
        pos = pos - NUM_CLIENTS;
      end
      if (!w_any_eligible && w_slot_elig[pos[IDW-1:0]]) begin
        w_any_eligible = 1'b1;
        w_rot_idx      = pos[IDW-1:0];
      end
    end
  end

  assign w_continue  = (quota_q != 8'd0) & w_slot_elig[last_q];
  assign w_grant_idx = w_continue ? last_q : w_rot_idx;
  assign w_credit_ok = (os_count_q < {1'b0, rd_os_cnt});

  // Reset gates the load so no client sees an accept while the block is held.
  assign w_load = nvdla_core_rstn & (~dma_req_valid_q | dma_req_ready) &
                  w_credit_ok & w_any_eligible;

  generate
    for (genvar gc = 0; gc < NUM_CLIENTS; gc++) begin : g_ready
      assign req_ready[gc] = w_load & (w_grant_idx == IDW'(gc));
    end
  endgenerate

  // A completion with nothing outstanding is spurious (e.g. a read that was
  // in flight across a reset) and is dropped so the counter cannot wrap.
  assign w_rsp_dec = rsp_done & (os_count_q != 9'd0);

  always_comb begin : p_next
    dma_req_valid_d = dma_req_valid_q;
    dma_req_pd_d    = dma_req_pd_q;
    dma_req_id_d    = dma_req_id_q;
    last_d          = last_q;
    quota_d         = quota_q;
    os_count_d      = os_count_q;

    // The current burst owner letting go forfeits the rest of its quota.
    if (!w_slot_valid[last_q]) begin
      quota_d = 8'd0;
    end

    if (w_load) begin
      dma_req_valid_d = 1'b1;
      dma_req_pd_d    = w_slot_pd[w_grant_idx];
      dma_req_id_d    = w_grant_idx;
      if (w_continue) begin
        quota_d = quota_q - 8'd1;
      end else begin
        // Weight is sampled only here, so mid-burst weight writes wait for
        // the next rotation.
        last_d  = w_grant_idx;
        quota_d = w_slot_weight[w_grant_idx] - 8'd1;
      end
    end else if (dma_req_ready) begin
      dma_req_valid_d = 1'b0;
    end

    if (w_load && !w_rsp_dec) begin
      os_count_d = os_count_q + 9'd1;
    end else if (!w_load && w_rsp_dec) begin
      os_count_d = os_count_q - 9'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dma_req_valid_q <= 1'b0;
      dma_req_pd_q    <= '0;
      dma_req_id_q    <= '0;
      last_q          <= c_last_rst;
      quota_q         <= 8'd0;
      os_count_q      <= 9'd0;
    end else begin
      dma_req_valid_q <= dma_req_valid_d;
      dma_req_pd_q    <= dma_req_pd_d;
      dma_req_id_q    <= dma_req_id_d;
      last_q          <= last_d;
      quota_q         <= quota_d;
      os_count_q      <= os_count_d;
    end
  end

  assign dma_req_valid = dma_req_valid_q;
  assign dma_req_pd    = dma_req_pd_q;
  assign dma_req_id    = dma_req_id_q;
  assign idle          = (os_count_q == 9'd0) & ~dma_req_valid_q & ~|req_valid;

endmodule
`default_nettype wire
